// File: rtl/stg_wb.sv
// Write-back stage: registers the MO payload, drives the GP/SR/AR register-file
// write ports, counts retired instructions and halts architectural updates after a HALT.
module stg_wb #(
  parameter int P_RETIRE_W  = 48,
  parameter int HBIT_ADDR   = 47,
  parameter int HBIT_DATA   = 23,
  parameter int HBIT_OPC    = 7,
  parameter int HBIT_TGT_GP = 3,
  parameter int HBIT_TGT_SR = 3,
  parameter int HBIT_TGT_AR = 3,
  parameter logic [HBIT_OPC:0] OPC_NOP  = '0,
  parameter logic [HBIT_OPC:0] OPC_HALT = 1
) (
  input  logic                   iw_clk,
  input  logic                   iw_rst,
  input  logic [HBIT_ADDR:0]     iw_pc,
  input  logic [HBIT_DATA:0]     iw_instr,
  input  logic [HBIT_OPC:0]      iw_opc,
  input  logic [HBIT_TGT_GP:0]   iw_tgt_gp,
  input  logic                   iw_tgt_gp_we,
  input  logic [HBIT_TGT_SR:0]   iw_tgt_sr,
  input  logic                   iw_tgt_sr_we,
  input  logic [HBIT_TGT_AR:0]   iw_tgt_ar,
  input  logic                   iw_tgt_ar_we,
  input  logic [HBIT_DATA:0]     iw_result,
  input  logic [HBIT_ADDR:0]     iw_sr_result,
  input  logic [HBIT_ADDR:0]     iw_ar_result,
  input  logic                   iw_stall,
  input  logic                   iw_resume,
  output logic                   ow_gp_we,
  output logic [HBIT_TGT_GP:0]   ow_gp_addr,
  output logic [HBIT_DATA:0]     ow_gp_data,
  output logic                   ow_sr_we,
  output logic [HBIT_TGT_SR:0]   ow_sr_addr,
  output logic [HBIT_ADDR:0]     ow_sr_data,
  output logic                   ow_ar_we,
  output logic [HBIT_TGT_AR:0]   ow_ar_addr,
  output logic [HBIT_ADDR:0]     ow_ar_data,
  output logic [HBIT_ADDR:0]     ow_pc,
  output logic [HBIT_DATA:0]     ow_instr,
  output logic [HBIT_OPC:0]      ow_opc,
  output logic                   ow_retired,
  output logic [P_RETIRE_W-1:0]  ow_retire_cnt,
  output logic                   ow_halted
);

  typedef enum logic {S_RUN, S_HALT} state_t;

  state_t state;
  logic   is_halt;
  logic   is_nop;

  assign is_halt = (iw_opc == OPC_HALT);
  assign is_nop  = (iw_opc == OPC_NOP);

  // Write enables and the retire pulse default low every cycle so that a held
  // payload (stall or HALT) can never be written twice.
  always_ff @(posedge iw_clk or negedge iw_rst) begin
    if (!iw_rst) begin
      state         <= S_RUN;
      ow_gp_we      <= 1'b0;
      ow_gp_addr    <= '0;
      ow_gp_data    <= '0;
      ow_sr_we      <= 1'b0;
      ow_sr_addr    <= '0;
      ow_sr_data    <= '0;
      ow_ar_we      <= 1'b0;
      ow_ar_addr    <= '0;
      ow_ar_data    <= '0;
      ow_pc         <= '0;
      ow_instr      <= '0;
      ow_opc        <= '0;
      ow_retired    <= 1'b0;
      ow_retire_cnt <= '0;
      ow_halted     <= 1'b0;
    end else begin
      ow_gp_we   <= 1'b0;
      ow_sr_we   <= 1'b0;
      ow_ar_we   <= 1'b0;
      ow_retired <= 1'b0;
      case (state)
        S_RUN: begin
          if (!iw_stall) begin
            ow_pc      <= iw_pc;
            ow_instr   <= iw_instr;
            ow_opc     <= iw_opc;
            ow_gp_addr <= iw_tgt_gp;
            ow_gp_data <= iw_result;
            ow_sr_addr <= iw_tgt_sr;
            ow_sr_data <= iw_sr_result;
            ow_ar_addr <= iw_tgt_ar;
            ow_ar_data <= iw_ar_result;
            ow_gp_we   <= iw_tgt_gp_we & ~is_halt;
            ow_sr_we   <= iw_tgt_sr_we & ~is_halt;
            ow_ar_we   <= iw_tgt_ar_we & ~is_halt;
            if (!is_nop) begin
              ow_retired    <= 1'b1;
              ow_retire_cnt <= ow_retire_cnt + 1'b1;
            end
            if (is_halt) begin
              state     <= S_HALT;
              ow_halted <= 1'b1;
            end
          end
        end
        S_HALT: begin
          // Resume is honoured even under stall; acceptance then waits for stall to drop.
          if (iw_resume) begin
            state     <= S_RUN;
            ow_halted <= 1'b0;
          end
        end
        default: state <= S_RUN;
      endcase
    end
  end

endmodule
